lsu_bus_master: RTL and testbench
=================================

# lsu_bus_master

Load/store unit bridging the RV32I core's memory control signals (MemRead, MemWrite, MemSize, MemSign) to the peripheral bus. It is the responder end of the decoder's memory-control outputs. For each core access it:
- converts the access into a word-aligned, byte-enabled bus transaction with a req/ack handshake;
- stalls the core until the transaction completes;
- returns lane-extracted, sign- or zero-extended load data.

Misaligned accesses are trapped without a bus cycle. Unanswered transactions are terminated by a timeout.

## Interface
- TIMEOUT_CYCLES, 255: maximum WAIT cycles without bus_ack before the access is aborted with bus_err. Range 1..65535.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mem_read  in  1  load request. Held stable by the core while stall=1.
- mem_write  in  1  store request. Has priority if asserted together with mem_read.
- mem_size  in  2  00=byte, 01=half, 10=word, 11 treated as word.
- mem_sign  in  1  1=sign-extend load result, 0=zero-extend.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- rdata  out  32  load result; valid in the DONE cycle.
- stall  out  1  holds the core pipeline.
- misaligned  out  1  access rejected for alignment (combinational, IDLE only).
- bus_err  out  1  access aborted by timeout; high during DONE only.
- bus_req  out  1  transaction request, registered.
- bus_we  out  1  1=write, registered.
- bus_addr  out  32  {addr[31:2],2'b00}, registered.
- bus_be  out  4  byte enables, registered.
- bus_wdata  out  32  lane-replicated store data, registered.
- bus_ack  in  1  responder completion. Ignored while bus_req=0.
- bus_rdata  in  32  read word; sampled on the bus_ack cycle.

## Operation
- FSM states: IDLE, WAIT, DONE.
- access = mem_write | mem_read.
- mis = (size half & addr[0]) | (size word & addr[1:0]≠0).
- IDLE:
  - If access & !mis: latch bus_we, bus_addr, bus_be, bus_wdata; set bus_req=1; clear the timeout counter; go to WAIT.
  - If access & mis: misaligned=1, stall=0, no bus cycle, rdata=0, stay in IDLE.
- WAIT:
  - bus_ack=1: capture the extended load data into rdata; bus_req=0; bus_err=0; go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 with no ack: bus_req=0, rdata=0, bus_err=1, go to DONE.
- DONE: stall=0; rdata and bus_err valid; unconditional transition to IDLE. The core retires the access at the end of this cycle, so it is never reissued.
- stall = (IDLE & access & !mis) | WAIT. Forced 0 while rst_n=0.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load data:
  - byte: lane = bus_rdata[8*addr[1:0] +: 8]
  - half: lane = bus_rdata[16*addr[1] +: 16]
  - Sign-extend when mem_sign=1, otherwise zero-extend.
  - mem_sign is ignored for word accesses.
- Stores leave rdata at 0 in DONE.
- bus_we, bus_addr, bus_be and bus_wdata hold their values from the start of WAIT until the next request is latched.

## Timing
- Reset values, applied one edge after rst_n=0:
  - state=IDLE
  - bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0
  - rdata=0, bus_err=0, counter=0
- Reset in any state aborts the pending transaction. bus_req drops on that edge and no DONE cycle is produced.
- Latency: request seen in cycle 0 → bus_req high from cycle 1 → ack in cycle k≥1 → DONE in cycle k+1. Minimum is 3 cycles, with stall high in cycles 0..k.
- Handshake:
  - The responder may ack in any cycle with bus_req=1.
  - bus_req never drops before ack or timeout.
  - At most one transaction is outstanding.
- An ack arriving in the same cycle as the timeout terminal count is taken as a successful ack (bus_err=0).
- Timeout: DONE occurs in cycle TIMEOUT_CYCLES+1 after the request, with bus_err=1.

## Test plan
- LW at 0x100, responder acks in cycle 1 with 0xDEADBEEF → bus_be=1111, bus_addr=0x100, stall high 2 cycles, rdata=0xDEADBEEF in DONE (cycle 2).
- LB at 0x103, signed, bus_rdata=0x80FF_0000 → bus_be=1000, rdata=0xFFFFFF80. Same access as LBU → rdata=0x00000080.
- SH at 0x202, wdata=0x1234ABCD, ack after 3 wait cycles → bus_we=1, bus_addr=0x200, bus_be=1100, bus_wdata=0xABCDABCD, stall high 4 cycles.
- LW at 0x101 → misaligned=1, stall=0, bus_req stays 0, rdata=0.
- TIMEOUT_CYCLES=4, LW with no ack → bus_req high cycles 1–4, DONE in cycle 5 with bus_err=1 and rdata=0. Then SB ack'd in cycle 1 → bus_err=0.
- rst_n=0 in the second WAIT cycle → next edge bus_req=0, state IDLE, all outputs at reset values. A late ack afterwards causes no DONE.

Source files
------------

// File: rtl/lsu_bus_master_if.sv
// Peripheral-bus side of the load/store unit: a single-outstanding req/ack
// handshake carrying a word address, byte enables and write/read data.
interface lsu_bus_master_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store unit: turns core MemRead/MemWrite accesses into word-aligned,
// byte-enabled bus transactions, stalls the core, and returns extended load data.
module lsu_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    lsu_bus_master_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [1:0]  off_q;

    logic        access;
    logic        is_half;
    logic        is_word;
    logic        mis;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_d;
    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign access  = mem_write_i | mem_read_i;
    assign is_half = (mem_size_i == 2'b01);
    assign is_word = mem_size_i[1];
    assign mis     = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
        case (mem_size_i)
            2'b00: begin
                be_d    = 4'b0001 << addr_i[1:0];
                wdata_d = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << addr_i[1:0];
                wdata_d = {2{wdata_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = wdata_i;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = bus.bus_rdata[8*gi +: 8];
        end
    endgenerate

    // Lane selection uses the offset/size latched at request time, not the live core inputs.
    assign sel_byte = rd_byte[off_q];
    assign sel_half = off_q[1] ? {rd_byte[3], rd_byte[2]} : {rd_byte[1], rd_byte[0]};

    always_comb begin
        load_d = bus.bus_rdata;
        case (size_q)
            2'b00:   load_d = {{24{sign_q & sel_byte[7]}}, sel_byte};
            2'b01:   load_d = {{16{sign_q & sel_half[15]}}, sel_half};
            default: load_d = bus.bus_rdata;
        endcase
        if (we_q) begin
            load_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            off_q   <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (access && !mis) begin
                        state_q <= ST_WAIT;
                        req_q   <= 1'b1;
                        we_q    <= mem_write_i;
                        addr_q  <= {addr_i[31:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        cnt_q   <= 16'd0;
                        size_q  <= mem_size_i;
                        sign_q  <= mem_sign_i;
                        off_q   <= addr_i[1:0];
                    end
                end
                ST_WAIT: begin
                    // An ack on the terminal-count cycle still wins over the timeout.
                    if (bus.bus_ack) begin
                        req_q   <= 1'b0;
                        rdata_q <= load_d;
                        err_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        rdata_q <= 32'd0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_DONE: begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_o      = rst_n & (((state_q == ST_IDLE) & access & ~mis) | (state_q == ST_WAIT));
    assign misaligned_o = rst_n & (state_q == ST_IDLE) & access & mis;
    assign rdata_o      = rdata_q;
    assign bus_err_o    = err_q;

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed table, random traffic against
// a byte-lane reference model, and hand-written misalign/reset sequences.
module tb_lsu_bus_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, mem_sign;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata, rdata;
    logic        stall, misaligned, bus_err;

    int tests = 0;
    int fails = 0;

    lsu_bus_master_if bus_if ();

    lsu_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read_i   (mem_read),
        .mem_write_i  (mem_write),
        .mem_size_i   (mem_size),
        .mem_sign_i   (mem_sign),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .rdata_o      (rdata),
        .stall_o      (stall),
        .misaligned_o (misaligned),
        .bus_err_o    (bus_err),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        rd;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdw;
        int          ack_k;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: each access touches nb consecutive bytes starting at offset off.
    function automatic void model(input logic we, input logic [1:0] size, input logic sign,
                                  input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                                  output logic [3:0] be, output logic [31:0] bwd, output logic [31:0] rd);
        int nb;
        int off;
        logic [31:0] mask;
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off  = (nb == 4) ? 0 : int'(a % 4);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        be   = 4'(((1 << nb) - 1) << off);
        bwd  = 32'd0;
        for (int i = 0; i < 4; i++) begin
            bwd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        rd = (rdw >> (8 * off)) & mask;
        if (sign && nb < 4 && rd[8*nb-1]) rd = rd | ~mask;
        if (we) rd = 32'd0;
    endfunction

    // Called #1 after a rising edge with the DUT idle; runs one access to its DONE cycle.
    task automatic run_access(input string nm, input vec_t v);
        int exp_done;
        exp_done  = (v.ack_k >= 1 && v.ack_k <= TO) ? v.ack_k + 1 : TO + 1;
        mem_write = v.we;
        mem_read  = v.rd;
        mem_size  = v.size;
        mem_sign  = v.sign;
        addr      = v.addr;
        wdata     = v.wd;
        for (int c = 0; c <= exp_done; c++) begin
            @(negedge clk);
            chk({nm, " stall"}, 32'(stall), 32'(c < exp_done));
            chk({nm, " bus_req"}, 32'(bus_if.bus_req), 32'(c >= 1 && c < exp_done));
            if (c == 0) chk({nm, " misaligned"}, 32'(misaligned), 32'd0);
            if (c == 1 || c == exp_done) begin
                chk({nm, " bus_we"}, 32'(bus_if.bus_we), 32'(v.we));
                chk({nm, " bus_addr"}, bus_if.bus_addr, v.addr & 32'hFFFF_FFFC);
                chk({nm, " bus_be"}, 32'(bus_if.bus_be), 32'(v.e_be));
                chk({nm, " bus_wdata"}, bus_if.bus_wdata, v.e_wd);
            end
            if (c == exp_done) begin
                chk({nm, " rdata"}, rdata, v.e_rd);
                chk({nm, " bus_err"}, 32'(bus_err), 32'(v.e_err));
            end
            bus_if.bus_ack   = (c == v.ack_k) && (c < exp_done);
            bus_if.bus_rdata = bus_if.bus_ack ? v.rdw : $urandom;
            @(posedge clk);
            #1;
        end
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk({nm, " idle stall"}, 32'(stall), 32'd0);
        chk({nm, " idle rdata"}, rdata, 32'd0);
        chk({nm, " idle bus_err"}, 32'(bus_err), 32'd0);
        $display("[TB] txn %s we=%0d size=%0d addr=0x%08h ack_k=%0d rdata=0x%08h err=%0d",
                 nm, v.we, v.size, v.addr, v.ack_k, v.e_rd, v.e_err);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80FF0000, 1, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 1, 4'h8, 32'h0,        32'h00000080, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 32'h0,        3, 4'hC, 32'hABCDABCD, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h0,        32'h12345678, 0, 4'hF, 32'h0,        32'h0,        1'b1};
        tbl[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h001, 32'h0000005A, 32'h0,        1, 4'h2, 32'h5A5A5A5A, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'd1, 1'b1, 32'h102, 32'h0,        32'h80011234, 2, 4'hC, 32'h0,        32'hFFFF8001, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h100, 32'h0,        32'h8001F234, 1, 4'h3, 32'h0,        32'h0000F234, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h10C, 32'h0,        32'h0BADF00D, 4, 4'hF, 32'h0,        32'h0BADF00D, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'd3, 1'b1, 32'h004, 32'h0,        32'h80000000, 1, 4'hF, 32'h0,        32'h80000000, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h008, 32'hCAFEF00D, 32'h11111111, 2, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0};

        rst_n = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2; mem_sign = 1'b0;
        addr = 32'h100; wdata = 32'h0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("reset bus_we", 32'(bus_if.bus_we), 32'd0);
        chk("reset bus_addr", bus_if.bus_addr, 32'd0);
        chk("reset bus_be", 32'(bus_if.bus_be), 32'd0);
        chk("reset bus_wdata", bus_if.bus_wdata, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset bus_err", 32'(bus_err), 32'd0);
        mem_read = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            run_access($sformatf("dir%0d", i), tbl[i]);
        end

        // Misaligned word load and half store: no bus cycle, no stall.
        for (int j = 0; j < 2; j++) begin
            mem_read  = (j == 0);
            mem_write = (j == 1);
            mem_size  = (j == 0) ? 2'd2 : 2'd1;
            addr      = (j == 0) ? 32'h101 : 32'h203;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                chk("mis flag", 32'(misaligned), 32'd1);
                chk("mis stall", 32'(stall), 32'd0);
                chk("mis bus_req", 32'(bus_if.bus_req), 32'd0);
                chk("mis rdata", rdata, 32'd0);
                @(posedge clk);
                #1;
            end
            $display("[TB] txn misaligned %0d addr=0x%08h", j, addr);
            mem_read = 1'b0; mem_write = 1'b0;
        end

        for (int i = 0; i < 40; i++) begin
            v.we    = 1'($urandom);
            v.rd    = ~v.we | 1'($urandom);
            v.size  = 2'($urandom);
            v.sign  = 1'($urandom);
            v.addr  = $urandom & 32'hFFFF_FFFC;
            if (v.size == 2'd0) v.addr[1:0] = 2'($urandom);
            if (v.size == 2'd1) v.addr[1] = 1'($urandom);
            v.wd    = $urandom;
            v.rdw   = $urandom;
            v.ack_k = $urandom_range(1, TO + 2);
            model(v.we, v.size, v.sign, v.addr, v.wd, v.rdw, v.e_be, v.e_wd, v.e_rd);
            v.e_err = (v.ack_k > TO);
            if (v.e_err) v.e_rd = 32'd0;
            run_access($sformatf("rnd%0d", i), v);
        end

        // Reset during the second WAIT cycle, then a late ack must not produce DONE.
        mem_read = 1'b1; mem_size = 2'd2; addr = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstwait bus_req pre", 32'(bus_if.bus_req), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstwait bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("rstwait bus_addr", bus_if.bus_addr, 32'd0);
        chk("rstwait bus_be", 32'(bus_if.bus_be), 32'd0);
        chk("rstwait stall", 32'(stall), 32'd0);
        mem_read = 1'b0;
        rst_n = 1'b1;
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = 32'hFFFFFFFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("late ack stall", 32'(stall), 32'd0);
            chk("late ack bus_req", 32'(bus_if.bus_req), 32'd0);
            chk("late ack bus_err", 32'(bus_err), 32'd0);
            chk("late ack rdata", rdata, 32'd0);
        end
        bus_if.bus_ack = 1'b0;
        $display("[TB] txn reset-in-wait addr=0x00000300");
        @(posedge clk); #1;
        run_access("post_reset", tbl[5]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
